// File: rtl/clock_manager.sv
// clock_manager
//   Divides the free-running CLK by a programmable divisor and produces a
//   registered divided clock (clk), a one-cycle period strobe (ce), a
//   stretched downstream reset (resetn) and a running count of ce pulses
//   (ticks). The divider can run continuously, pause, or single-step one
//   full period per rising edge of step_i.
//
// Ports
//   CLK     in   source clock; all logic is on its rising edge
//   RESET   in   asynchronous active-low reset
//   div_i   in   requested divisor; 0 behaves as 1; sampled only at wrap
//   mode_i  in   00 run, 01 pause, 10 step, 11 run
//   step_i  in   step request level; rising edge starts one period
//   clk     out  divided clock, registered
//   ce      out  one-CLK strobe per completed divided period
//   resetn  out  active-low reset, released SYNC_STAGES+RST_HOLD edges
//                after RESET rises
//   ticks   out  number of ce pulses since reset, wraps at 2^32
module clock_manager #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DIV_DEFAULT = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RST_HOLD    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] div_i,
    input  logic [1:0]       mode_i,
    input  logic             step_i,
    output logic             clk,
    output logic             ce,
    output logic             resetn,
    output logic [31:0]      ticks
);

    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int unsigned HOLD_N = (RST_HOLD < 1) ? 1 : RST_HOLD;
    localparam int unsigned HOLD_W = $clog2(HOLD_N + 1);

    localparam logic [WIDTH-1:0]  ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]  DIV_RST   = (DIV_DEFAULT == 0) ? ONE : WIDTH'(DIV_DEFAULT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_N - 1);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_PAUSE = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_RUN2  = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(mode_i);

    // Release sequencer state
    logic [SYNC_N-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              resetn_q, resetn_d;

    // Divider state
    logic [WIDTH-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic              clk_q, clk_d;
    logic              ce_q, ce_d;
    logic [31:0]       ticks_q, ticks_d;
    logic              step_prev_q, step_prev_d;

    logic              count_en;
    logic              wrap;
    logic              step_rise;
    logic [WIDTH:0]    half;
    logic [WIDTH-1:0]  div_in;

    // Release sequencer: synchronise RESET deassertion, then hold resetn low
    // for HOLD_N further edges.
    always_comb begin
        sync_d   = {sync_q[SYNC_N-2:0], 1'b1};
        hold_d   = hold_q;
        resetn_d = resetn_q;
        if (sync_q[SYNC_N-1] && !resetn_q) begin
            if (hold_q == HOLD_LAST) begin
                resetn_d = 1'b1;
            end else begin
                hold_d = hold_q + HOLD_W'(1);
            end
        end
    end

    always_comb begin
        step_rise   = step_i & ~step_prev_q;
        step_prev_d = step_i;
        div_in      = (div_i == '0) ? ONE : div_i;
        half        = ({1'b0, div_q} + (WIDTH + 1)'(1)) >> 1;

        // While resetn is held low the divider free-runs so downstream
        // synchronous logic sees clk/ce during its reset. In step mode a
        // non-zero phase means a period is in flight (a step, or a period
        // interrupted by the mode change); it always runs to completion, so
        // "idle" is simply cnt==0 and edges seen mid-period are ignored.
        if (!resetn_q) begin
            count_en = 1'b1;
        end else begin
            case (mode)
                MODE_PAUSE: count_en = 1'b0;
                MODE_STEP:  count_en = (cnt_q != '0) || step_rise;
                default:    count_en = 1'b1;
            endcase
        end

        wrap  = count_en && (cnt_q == div_q - ONE);
        cnt_d = cnt_q;
        div_d = div_q;
        clk_d = clk_q;
        ce_d  = 1'b0;

        if (count_en) begin
            // clk follows the phase of the previous cycle; divisor 1 keeps it low
            clk_d = (div_q != ONE) && ({1'b0, cnt_q} < half);
            if (wrap) begin
                cnt_d = '0;
                div_d = div_in;
                ce_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end

        ticks_d = ticks_q + 32'(ce_q);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync_q      <= '0;
            hold_q      <= '0;
            resetn_q    <= 1'b0;
            cnt_q       <= '0;
            div_q       <= DIV_RST;
            clk_q       <= 1'b0;
            ce_q        <= 1'b0;
            ticks_q     <= '0;
            step_prev_q <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            hold_q      <= hold_d;
            resetn_q    <= resetn_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            clk_q       <= clk_d;
            ce_q        <= ce_d;
            ticks_q     <= ticks_d;
            step_prev_q <= step_prev_d;
        end
    end

    assign clk    = clk_q;
    assign ce     = ce_q;
    assign resetn = resetn_q;
    assign ticks  = ticks_q;

endmodule

// File: tb/tb_clock_manager.sv
// Testbench for clock_manager. Stimulus pushes the CLK edge numbers at which
// ce must pulse; a negedge monitor pops and compares them, and checks ticks
// against the number of ce pulses seen since reset.
module tb_clock_manager;

    localparam int unsigned WIDTH = 16;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic [WIDTH-1:0] div_i;
    logic [1:0]       mode_i;
    logic             step_i;
    logic             clk;
    logic             ce;
    logic             resetn;
    logic [31:0]      ticks;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int ce_seen = 0;
    int base;
    int exp_q[$];

    clock_manager #(
        .WIDTH       (WIDTH),
        .DIV_DEFAULT (1),
        .SYNC_STAGES (2),
        .RST_HOLD    (8)
    ) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .div_i  (div_i),
        .mode_i (mode_i),
        .step_i (step_i),
        .clk    (clk),
        .ce     (ce),
        .resetn (resetn),
        .ticks  (ticks)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (!RESET) begin
            ce_seen = 0;
        end else begin
            while (exp_q.size() > 0 && exp_q[0] < edge_cnt) begin
                checks++;
                errors++;
                $display("FAIL ce_missing actual=no_pulse required=pulse_at_edge_%0d", exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (ce === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ce_unexpected actual=pulse_at_edge_%0d required=no_pulse", edge_cnt);
                end else begin
                    check("ce_edge", 32'(edge_cnt), 32'(exp_q.pop_front()));
                end
                check("ticks_at_ce", ticks, 32'(ce_seen));
                ce_seen++;
            end
        end
    end

    // Release RESET with divisor request 2 and pause mode: only the forced
    // counting during the hold phase runs (divisor 1 for the first period,
    // then 2), so ce pulses on edges 1,3,5,7,9 and clk alternates.
    task automatic release_seq();
        int b;
        RESET = 1'b1;
        b = edge_cnt;
        for (int k = 1; k <= 9; k += 2) exp_q.push_back(b + k);
        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            check("resetn_release", 32'(resetn), (k == 10) ? 32'd1 : 32'd0);
            check("clk_hold", 32'(clk), (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        check("ticks_after_release", ticks, 32'd5);
        check("clk_frozen_after_release", 32'(clk), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        div_i  = 16'd2;
        mode_i = 2'b01;
        step_i = 1'b0;
        RESET  = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_resetn", 32'(resetn), 32'd0);
        check("reset_clk", 32'(clk), 32'd0);
        check("reset_ce", 32'(ce), 32'd0);
        check("reset_ticks", ticks, 32'd0);

        release_seq();

        // Run D=5, divisor change 5->3 mid-period, pause, step mode
        div_i  = 16'd5;
        mode_i = 2'b00;
        base   = edge_cnt;
        exp_q.push_back(base + 1);
        exp_q.push_back(base + 6);
        exp_q.push_back(base + 11);
        exp_q.push_back(base + 16);
        exp_q.push_back(base + 21);
        exp_q.push_back(base + 24);
        exp_q.push_back(base + 27);
        exp_q.push_back(base + 42);
        exp_q.push_back(base + 48);
        exp_q.push_back(base + 56);
        for (int e = 1; e <= 62; e++) begin
            @(negedge CLK);
            if (e >= 2 && e <= 16) check("clk_d5", 32'(clk), (((e - 2) % 5) < 3) ? 32'd1 : 32'd0);
            if (e >= 30 && e <= 39) begin
                check("clk_paused", 32'(clk), 32'd1);
                check("ticks_paused", ticks, 32'd12);
            end
            if (e == 40) check("clk_resume_hi", 32'(clk), 32'd1);
            if (e == 41) check("clk_resume_lo", 32'(clk), 32'd0);
            if (e >= 49 && e <= 52) check("clk_step_frozen", 32'(clk), 32'd0);
            if (e == 62) check("clk_mid_step", 32'(clk), 32'd1);
            case (e)
                18: div_i = 16'd3;
                24: div_i = 16'd5;
                29: mode_i = 2'b01;
                39: begin mode_i = 2'b00; div_i = 16'd4; end
                42: mode_i = 2'b10;
                44, 46, 52, 60: step_i = 1'b1;
                45, 47, 53, 61: step_i = 1'b0;
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a step period
        RESET = 1'b0;
        #1;
        check("async_resetn", 32'(resetn), 32'd0);
        check("async_clk", 32'(clk), 32'd0);
        check("async_ce", 32'(ce), 32'd0);
        check("async_ticks", ticks, 32'd0);
        repeat (3) @(negedge CLK);
        mode_i = 2'b01;
        div_i  = 16'd2;
        step_i = 1'b0;
        release_seq();

        // Divisor 0 behaves as 1: ce every edge, clk low
        div_i  = 16'd0;
        mode_i = 2'b00;
        base   = edge_cnt;
        for (int k = 1; k <= 6; k++) exp_q.push_back(base + k);
        for (int e = 1; e <= 6; e++) begin
            @(negedge CLK);
            check("clk_div0", 32'(clk), 32'd0);
            if (e == 6) mode_i = 2'b01;
        end
        repeat (3) @(negedge CLK);
        check("ce_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_manager.md
CLOCK_MANAGER -- requirements
Module: clock_manager

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, meaning divider counter / divisor width in bits.
REQ-002 SHALL provide parameter DIV_DEFAULT, default 1, meaning divisor loaded at reset.
REQ-003 SHALL provide parameter SYNC_STAGES, default 2 (min 2), meaning reset-release synchroniser depth.
REQ-004 SHALL provide parameter RST_HOLD, default 8 (min 1), meaning CLK cycles resetn stays low after synchronised release.
REQ-005 SHALL provide port CLK  input  1  free-running source clock, all logic on rising edge.
REQ-006 SHALL provide port RESET  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 SHALL provide port div_i  input  WIDTH  requested divisor D; 0 treated as 1.
REQ-008 SHALL provide port mode_i  input  2  00 run, 01 pause, 10 step, 11 run.
REQ-009 SHALL provide port step_i  input  1  step request, level; rising edge detected internally.
REQ-010 SHALL provide port clk  output  1  divided clock, registered.
REQ-011 SHALL provide port ce  output  1  one-CLK-cycle strobe per completed divided period, registered.
REQ-012 SHALL provide port resetn  output  1  stretched active-low reset for downstream logic.
REQ-013 SHALL provide port ticks  output  32  count of ce pulses since reset, wraps at 2^32.

Function
REQ-014 SHALL hold internal divisor div_q (reset DIV_DEFAULT, 0 mapped to 1) and phase counter cnt (reset 0), range 0..div_q-1.
REQ-015 SHALL, when counting enabled, advance cnt each CLK; at cnt==div_q-1 wrap to 0, load div_q from div_i (0->1), assert ce next cycle.
REQ-016 SHALL drive clk high while cnt < ceil(div_q/2), low otherwise (D=5: 3 high/2 low; D=2: 1/1), registered with one-CLK lag.
REQ-017 SHALL, for div_q==1, hold clk at 0 and assert ce every counting cycle.
REQ-018 SHALL never change div_q mid-period; div_i changes apply only at wrap.
REQ-019 SHALL in run mode count every CLK.
REQ-020 SHALL in pause mode freeze cnt, hold clk at current value, hold ce low; returning to run resumes from frozen cnt.
REQ-021 SHALL in step mode, on step_i rising edge with cnt==0 and idle, run exactly one full period (div_q counts, one ce), then freeze at cnt==0.
REQ-022 SHALL ignore step_i edges while a step period is in progress; entering step mode mid-period completes that period then freezes.
REQ-023 SHALL treat a mode change as effective on the next CLK edge.
REQ-024 SHALL increment ticks on each cycle ce is 1.
REQ-025 SHALL during the RST_HOLD phase (RESET high, resetn low) force run-mode counting so clk/ce toggle for synchronous downstream reset.

Reset
REQ-026 SHALL, on RESET low, asynchronously set resetn=0, clk=0, ce=0, ticks=0, cnt=0, div_q=DIV_DEFAULT, step state idle, hold counter 0.
REQ-027 SHALL synchronise RESET deassertion through SYNC_STAGES flops before hold phase begins.
REQ-028 SHALL raise resetn exactly SYNC_STAGES+RST_HOLD CLK rising edges after RESET rises.
REQ-029 SHALL, on RESET low mid-operation (any mode, mid-period, mid-step), abort immediately and restart the full release sequence.
REQ-030 SHALL keep resetn glitch-free: single rising transition per release sequence, synchronous to CLK.

Verification
REQ-031 SHALL verify: SYNC_STAGES=2, RST_HOLD=8, RESET rises -> resetn 0 for 9 edges, 1 on edge 10; clk/ce active during hold.
REQ-032 SHALL verify: div_i=5, run -> ce every 5 CLK, clk 3 high/2 low, ticks +1 per ce; div_i=0 -> ce every CLK, clk 0.
REQ-033 SHALL verify: div_i 5->3 at cnt==2 -> current period ends at 5, next periods 3 CLK.
REQ-034 SHALL verify: pause at cnt==2 for 10 CLK -> cnt, clk frozen, ce 0, ticks unchanged; run resumes, ce 3 CLK later (D=5).
REQ-035 SHALL verify: step mode, D=4, two step_i pulses 2 CLK apart -> exactly one ce, second ignored; later pulse -> one more ce.
REQ-036 SHALL verify: RESET low mid-step -> all outputs 0 same cycle (async), ticks 0, full release sequence repeats.
